// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port 256x64 data memory between the fetch
// requester (F, read only) and the memory-stage requester (D, read/write).
// Each access runs as a registered multi-cycle transaction; addresses above
// ADDR_LIMIT complete with an error and never reach the memory.
// Build option MEMARB_ROUND_ROBIN_EN: alternate grants between F and D instead
// of D priority with the starvation guard.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// ISSUE  | mem_en strobe for a legal access
// WAIT   | read in flight, MEM_LAT cycles until mem_rdata is valid
// DONE   | owner's done pulse (read data already captured)
// ERR    | owner's done+err pulse, memory untouched
module mem_port_arbiter #(
  parameter int unsigned ADDR_LIMIT = 255,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_done,
  output logic        f_err,
  output logic [63:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_done,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        owner_f_q, owner_f_d;   // 1: fetch port owns the transaction
  logic        we_q, we_d;
  logic [2:0]  wait_q;

  logic        req_any, grant, pick_f, sel_err, fin, capture;
  logic [63:0] sel_addr;

  logic        mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        f_done_q, f_done_d, f_err_q, f_err_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic [63:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
  logic        busy_q, busy_d;

  assign req_any = f_req | d_req;
  assign grant   = (state_q == S_IDLE) & req_any;

`ifdef MEMARB_ROUND_ROBIN_EN
  logic last_d_q;   // reset 0 so the first contested grant goes to D

  assign pick_f = f_req & (~d_req | last_d_q);

  // remember which port won the most recent grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (grant) begin
      last_d_q <= ~pick_f;
    end
  end
`else
  logic [3:0] starve_q;

  assign pick_f = f_req & (~d_req | (starve_q == 4'(STARVE_MAX)));

  // count D grants taken while F was waiting; an F grant clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
    end else if (grant) begin
      if (pick_f) begin
        starve_q <= 4'd0;
      end else if (f_req && (starve_q != 4'(STARVE_MAX))) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end
`endif

  assign sel_addr = pick_f ? f_addr : d_addr;
  assign sel_err  = (sel_addr > 64'(ADDR_LIMIT));

  // state register plus the latched owner and direction of the transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_f_q <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_f_q <= owner_f_d;
      we_q      <= we_d;
    end
  end

  // next-state: arbitrate in IDLE, then walk the transaction to completion
  always_comb begin
    state_d   = state_q;
    owner_f_d = owner_f_q;
    we_d      = we_q;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          owner_f_d = pick_f;
          we_d      = ~pick_f & d_we;
          state_d   = sel_err ? S_ERR : S_ISSUE;
        end
      end
      S_ISSUE: state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (wait_q == 3'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // read-latency down-counter, loaded while the strobe is out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q <= 3'd0;
    end else if (state_q == S_ISSUE) begin
      wait_q <= 3'(MEM_LAT - 1);
    end else if ((state_q == S_WAIT) && (wait_q != 3'd0)) begin
      wait_q <= wait_q - 3'd1;
    end
  end

  // outputs: next values of the output registers, derived from the next state
  always_comb begin
    mem_en_d    = (state_d == S_ISSUE);
    mem_we_d    = (state_d == S_ISSUE) & we_d;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (grant) begin
      mem_addr_d  = sel_addr[7:0];
      mem_wdata_d = pick_f ? 64'd0 : d_wdata;
    end
    fin      = (state_d == S_DONE) | (state_d == S_ERR);
    f_done_d = fin & owner_f_d;
    d_done_d = fin & ~owner_f_d;
    f_err_d  = (state_d == S_ERR) & owner_f_d;
    d_err_d  = (state_d == S_ERR) & ~owner_f_d;
    busy_d   = (state_d != S_IDLE);
    capture   = (state_q == S_WAIT) & (state_d == S_DONE);
    f_rdata_d = f_rdata_q;
    d_rdata_d = d_rdata_q;
    if (capture) begin
      if (owner_f_q) f_rdata_d = mem_rdata;
      else           d_rdata_d = mem_rdata;
    end
  end

  // output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 8'd0;
      mem_wdata_q <= 64'd0;
      f_done_q    <= 1'b0;
      f_err_q     <= 1'b0;
      d_done_q    <= 1'b0;
      d_err_q     <= 1'b0;
      f_rdata_q   <= 64'd0;
      d_rdata_q   <= 64'd0;
      busy_q      <= 1'b0;
    end else begin
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      f_done_q    <= f_done_d;
      f_err_q     <= f_err_d;
      d_done_q    <= d_done_d;
      d_err_q     <= d_err_d;
      f_rdata_q   <= f_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign f_done    = f_done_q;
  assign f_err     = f_err_q;
  assign d_done    = d_done_q;
  assign d_err     = d_err_q;
  assign f_rdata   = f_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int ADDR_LIMIT = 255;
  localparam int MEM_LAT    = 3;
  localparam int STARVE_MAX = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_we;
  logic [63:0] f_addr, d_addr, d_wdata, mem_rdata;
  logic        f_done, f_err, d_done, d_err, mem_en, mem_we, busy;
  logic [63:0] f_rdata, d_rdata, mem_wdata;
  logic [7:0]  mem_addr;

  mem_port_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input int i);
    return (64'h9E37_79B9_7F4A_7C15 * 64'(i + 1)) ^ 64'(i);
  endfunction

  // memory environment: MEM_LAT-deep read pipeline, garbage when not reading
  logic [63:0] ram [256];
  logic [63:0] pipe [MEM_LAT];
  logic        ram_init = 1'b0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
      ram_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : {$urandom, $urandom};
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MEM_LAT-1];

  // reference model: one transaction record, timing from edge arithmetic
  int          cyc = 0;
  bit          m_act = 0, m_f = 0, m_we = 0, m_err = 0, m_pick = 0, m_last_d = 0;
  int          m_g = 0, m_done = 0, m_next = 0, m_starve = 0;
  logic [7:0]  m_addr = 8'd0;
  logic [63:0] m_wdata = 64'd0, m_rd = 64'd0, m_a64 = 64'd0;
  logic [63:0] ref_mem [256];
  logic [63:0] e_f_rdata = 64'd0, e_d_rdata = 64'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_next = 0; m_starve = 0; m_last_d = 0;
      e_f_rdata = 64'd0; e_d_rdata = 64'd0;
    end else begin
      cyc++;
      if (m_act && m_we && !m_err && cyc == m_g + 1) ref_mem[m_addr] = m_wdata;
      if (m_act && cyc > m_done) m_act = 0;
      if (!m_act && cyc >= m_next && (f_req || d_req)) begin
`ifdef MEMARB_ROUND_ROBIN_EN
        m_pick   = f_req && (!d_req || m_last_d);
        m_last_d = !m_pick;
`else
        m_pick = f_req && (!d_req || m_starve == STARVE_MAX);
        if (m_pick) m_starve = 0;
        else if (f_req && m_starve < STARVE_MAX) m_starve++;
`endif
        m_act   = 1;
        m_f     = m_pick;
        m_we    = !m_pick && d_we;
        m_a64   = m_pick ? f_addr : d_addr;
        m_err   = (m_a64 > 64'(ADDR_LIMIT));
        m_addr  = m_a64[7:0];
        m_wdata = m_pick ? 64'd0 : d_wdata;
        m_rd    = ref_mem[m_addr];
        m_g     = cyc;
        m_done  = m_err ? cyc : (m_we ? cyc + 1 : cyc + 1 + MEM_LAT);
        m_next  = m_done + 2;
      end
      if (m_act && !m_err && !m_we && cyc == m_done) begin
        if (m_f) e_f_rdata = m_rd;
        else     e_d_rdata = m_rd;
      end
    end
  end

  function automatic bit done_now(input bit is_f);
    return m_act && (m_f == is_f) && (cyc == m_done);
  endfunction

  // per-cycle comparison of every output against the model
  bit e_en, e_fd, e_dd;
  always @(negedge clk) begin
    e_en = m_act && !m_err && (cyc == m_g);
    e_fd = m_act && m_f && (cyc == m_done);
    e_dd = m_act && !m_f && (cyc == m_done);
    check_eq("busy", 64'(busy), 64'(m_act));
    check_eq("mem_en", 64'(mem_en), 64'(e_en));
    check_eq("mem_we", 64'(mem_we), 64'(e_en && m_we));
    if (e_en) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(m_addr));
      if (m_we) check_eq("mem_wdata", mem_wdata, m_wdata);
    end
    check_eq("f_done", 64'(f_done), 64'(e_fd));
    check_eq("f_err", 64'(f_err), 64'(e_fd && m_err));
    check_eq("d_done", 64'(d_done), 64'(e_dd));
    check_eq("d_err", 64'(d_err), 64'(e_dd && m_err));
    check_eq("f_rdata", f_rdata, e_f_rdata);
    check_eq("d_rdata", d_rdata, e_d_rdata);
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    check_eq({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check_eq({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check_eq({tag, "_done"}, 64'({f_done, d_done, f_err, d_err}), 64'd0);
    check_eq({tag, "_f_rdata"}, f_rdata, 64'd0);
    check_eq({tag, "_d_rdata"}, d_rdata, 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // assert reset between edges, check outputs at once, release on next negedge
  task automatic pulse_reset(input string tag);
    #2 rst_n = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_txn(input bit is_f, input bit we, input logic [63:0] addr,
                         input logic [63:0] wdata);
    bit seen = 0;
    if (is_f) begin
      f_req = 1'b1; f_addr = addr;
    end else begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = is_f ? f_done : d_done;
    end
    if (is_f) f_req = 1'b0;
    else      d_req = 1'b0;
    check_eq("txn_done", 64'(seen), 64'd1);
  endtask

  task automatic wait_grant(input bit is_f);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_act && (m_f == is_f) && (cyc == m_g)) break;
    end
  endtask

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(7))
      0: return 64'd256;
      1: return 64'h1_0000;
      2: return {$urandom, $urandom};
      3: return 64'd255;
      4: return 64'd0;
      default: return 64'($urandom_range(255));
    endcase
  endfunction

  task automatic drive_random();
    if (f_req && done_now(1'b1)) begin
      if ($urandom_range(2) != 0) f_addr = rand_addr();
      else f_req = 1'b0;
    end else if (f_req && m_act && m_f) begin
      f_addr = {$urandom, $urandom};
      if ($urandom_range(15) == 0) f_req = 1'b0;
    end else if (!f_req && !(m_act && m_f) && $urandom_range(3) == 0) begin
      f_req = 1'b1; f_addr = rand_addr();
    end
    if (d_req && done_now(1'b0)) begin
      if ($urandom_range(2) != 0) begin
        d_addr = rand_addr(); d_we = 1'($urandom_range(1)); d_wdata = {$urandom, $urandom};
      end else d_req = 1'b0;
    end else if (d_req && m_act && !m_f) begin
      d_addr = {$urandom, $urandom}; d_we = 1'($urandom_range(1)); d_wdata = {$urandom, $urandom};
      if ($urandom_range(15) == 0) d_req = 1'b0;
    end else if (!d_req && !(m_act && !m_f) && $urandom_range(3) == 0) begin
      d_req = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom_range(1)); d_wdata = {$urandom, $urandom};
    end
  endtask

  bit         got [8];
  int         n_got;
  int         n_pulse;
  logic [7:0] exp_order;

  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    f_addr = 64'd0; d_addr = 64'd0; d_wdata = 64'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // write then read back through D
    run_txn(1'b0, 1'b1, 64'h20, 64'h1122_3344_5566_7788);
    run_txn(1'b0, 1'b0, 64'h20, 64'd0);
    check_eq("rd_back_data", d_rdata, 64'h1122_3344_5566_7788);
    check_eq("rd_back_err", 64'(d_err), 64'd0);

    // out-of-range addresses on both ports
    run_txn(1'b0, 1'b0, 64'd256, 64'd0);
    check_eq("d_range_err", 64'(d_err), 64'd1);
    run_txn(1'b1, 1'b0, 64'h1_0000, 64'd0);
    check_eq("f_range_err", 64'(f_err), 64'd1);

    // both requesters held high: grant order
`ifdef MEMARB_ROUND_ROBIN_EN
    exp_order = 8'b1010_1010;
`else
    exp_order = 8'b1000_1000;
`endif
    f_req = 1'b1; f_addr = 64'h8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h9;
    n_got = 0;
    for (int c = 0; c < 200 && n_got < 8; c++) begin
      @(negedge clk);
      if (f_done) begin got[n_got] = 1'b1; n_got++; end
      else if (d_done) begin got[n_got] = 1'b0; n_got++; end
    end
    f_req = 1'b0; d_req = 1'b0;
    check_eq("grant_count", 64'(n_got), 64'd8);
    for (int i = 0; i < n_got; i++)
      check_eq($sformatf("grant_order%0d", i), 64'(got[i]), 64'(exp_order[i]));
    repeat (3) @(negedge clk);

    // fetch drops its request mid-transaction: still exactly one done
    f_req = 1'b1; f_addr = 64'h05;
    wait_grant(1'b1);
    @(negedge clk);
    f_req = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (f_done) n_pulse++;
    end
    check_eq("f_drop_one_done", 64'(n_pulse), 64'd1);

    // reset during the ISSUE cycle of a write: write is lost, reissue works
    run_txn(1'b0, 1'b1, 64'h10, 64'hAAAA_0000_1111_2222);
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h10; d_wdata = 64'hBBBB_3333_4444_5555;
    wait_grant(1'b0);
    check_eq("issue_strobe", 64'(mem_en), 64'd1);
    pulse_reset("rst_issue");
    run_txn(1'b0, 1'b0, 64'h10, 64'd0);
    check_eq("lost_write", d_rdata, 64'hAAAA_0000_1111_2222);
    run_txn(1'b0, 1'b1, 64'h10, 64'hBBBB_3333_4444_5555);
    run_txn(1'b0, 1'b0, 64'h10, 64'd0);
    check_eq("reissued_write", d_rdata, 64'hBBBB_3333_4444_5555);

    // random traffic with occasional mid-stream resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 700 == 350) pulse_reset("rst_rand");
      else drive_random();
    end
    f_req = 1'b0; d_req = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

endmodule
